// File: rtl/axis_trigger_capture_if.sv
// AXI4-Stream bundle used on both sides of the trigger capture framer.
// tvalid/tready: a beat moves when both are high in the same cycle; the source never waits on tready.
interface axis_trigger_capture_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_trigger_capture.sv
// Acquisition framer: forwards a pre-trigger window, waits for a masked level/edge
// trigger, forwards a post-trigger window and closes the packet with tlast.
module axis_trigger_capture #(
  parameter int DATA_WIDTH  = 32,
  parameter int TRIG_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   stream_clk,
  input  logic                   stream_resetn,
  input  logic [TRIG_WIDTH-1:0]  trigger,
  input  logic [TRIG_WIDTH-1:0]  trigger_enable,
  input  logic [TRIG_WIDTH-1:0]  trigger_edge,
  input  logic [COUNT_WIDTH-1:0] prebuffer_beats,
  input  logic [COUNT_WIDTH-1:0] posttrigger_beats,
  input  logic                   start,
  input  logic                   abort,
  output logic                   idle,
  output logic [TRIG_WIDTH-1:0]  trigger_detected,
  output logic [COUNT_WIDTH-1:0] trigger_position,
  output logic                   overflow,
  axis_trigger_capture_if.slave  s_axis,
  axis_trigger_capture_if.master m_axis,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREBUFFER = 3'd1,
    ARMED     = 3'd2,
    POST      = 3'd3,
    FLUSH     = 3'd4
  } state_t;

  state_t                 state, state_d;
  logic [COUNT_WIDTH-1:0] shadow_pre, shadow_post;
  logic [TRIG_WIDTH-1:0]  shadow_en, shadow_edge;
  logic [COUNT_WIDTH-1:0] pre_cnt, post_cnt, total_cnt, total_next;
  logic [TRIG_WIDTH-1:0]  trigger_q, hit_vec;
  logic                   active, beat, hit, trig_beat, start_acc;
  logic                   tlast, tuser;
  logic                   unused_s_sideband;

  // The source is free-running, so the slave side never stalls.
  assign s_axis.tready     = 1'b1;
  assign unused_s_sideband = ^{s_axis.tlast, s_axis.tuser};

  assign active    = (state != IDLE);
  assign beat      = active && s_axis.tvalid;
  assign start_acc = (state == IDLE) && start;

  assign m_axis.tdata  = active ? s_axis.tdata : '0;
  assign m_axis.tvalid = beat;
  assign m_axis.tlast  = tlast;
  assign m_axis.tuser  = tuser;

  assign idle      = (state == IDLE);
  assign dbg_state = state;

  // Edge bits compare against last cycle's trigger; level bits use the raw input.
  assign hit_vec    = shadow_en & ((shadow_edge & trigger & ~trigger_q) | (~shadow_edge & trigger));
  assign hit        = |hit_vec;
  assign trig_beat  = (state == ARMED) && beat && hit;
  assign total_next = (total_cnt == '1) ? total_cnt : total_cnt + 1'b1;

  always_comb begin
    state_d = state;
    tlast   = 1'b0;
    tuser   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = (prebuffer_beats == '0) ? ARMED : PREBUFFER;
      end
      PREBUFFER: begin
        if (abort)                                         state_d = FLUSH;
        else if (beat && (pre_cnt + 1'b1 == shadow_pre))   state_d = ARMED;
      end
      ARMED: begin
        if (trig_beat) begin
          tuser = 1'b1;
          if (shadow_post == '0) begin
            tlast   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = abort ? FLUSH : POST;
          end
        end else if (abort) begin
          state_d = FLUSH;
        end
      end
      POST: begin
        // The normal closing beat takes priority over a coincident abort.
        if (beat && (post_cnt + 1'b1 == shadow_post)) begin
          tlast   = 1'b1;
          state_d = IDLE;
        end else if (abort) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (beat) begin
          tlast   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge stream_clk or negedge stream_resetn) begin
    if (!stream_resetn) state <= IDLE;
    else                state <= state_d;
  end

  always_ff @(posedge stream_clk or negedge stream_resetn) begin
    if (!stream_resetn) begin
      trigger_q <= '0;
    end else begin
      trigger_q <= trigger;
    end
  end

  always_ff @(posedge stream_clk or negedge stream_resetn) begin
    if (!stream_resetn) begin
      shadow_pre       <= '0;
      shadow_post      <= '0;
      shadow_en        <= '0;
      shadow_edge      <= '0;
      pre_cnt          <= '0;
      post_cnt         <= '0;
      total_cnt        <= '0;
      trigger_detected <= '0;
      trigger_position <= '0;
      overflow         <= 1'b0;
    end else if (start_acc) begin
      shadow_pre       <= prebuffer_beats;
      shadow_post      <= posttrigger_beats;
      shadow_en        <= trigger_enable;
      shadow_edge      <= trigger_edge;
      pre_cnt          <= '0;
      post_cnt         <= '0;
      total_cnt        <= '0;
      trigger_position <= '0;
      overflow         <= 1'b0;
    end else if (beat) begin
      total_cnt <= total_next;
      if (!m_axis.tready) overflow <= 1'b1;
      if (state == PREBUFFER && pre_cnt != shadow_pre)  pre_cnt  <= pre_cnt + 1'b1;
      if (state == POST && post_cnt != shadow_post)     post_cnt <= post_cnt + 1'b1;
      if (trig_beat) begin
        trigger_detected <= hit_vec;
        trigger_position <= total_next;
      end
    end
  end

endmodule

// File: doc/axis_trigger_capture.md
# axis_trigger_capture

Parametrised AXI4-Stream acquisition framer that sits between a free-running sample source and a DMA write channel. It forwards a configurable pre-trigger window and waits for a masked per-bit level or edge trigger. It then forwards a configurable post-trigger window and terminates the packet with tlast. It adds a trigger-beat marker on tuser, software abort with flush, configuration shadowing, a trigger-position readback and a sticky overflow flag for beats lost to downstream backpressure.

## Interface
- DATA_WIDTH, 32, width of s_tdata/m_tdata
- TRIG_WIDTH, 32, number of trigger input bits
- COUNT_WIDTH, 32, width of beat counters and beat-count config registers
- stream_clk  in  1  stream clock; all logic is in this domain
- stream_resetn  in  1  reset, asynchronous, active-low
- trigger  in  TRIG_WIDTH  trigger inputs, synchronous to stream_clk
- trigger_enable  in  TRIG_WIDTH  per-bit trigger mask
- trigger_edge  in  TRIG_WIDTH  per-bit mode: 1 = rising edge, 0 = high level
- prebuffer_beats  in  COUNT_WIDTH  beats forwarded before arming
- posttrigger_beats  in  COUNT_WIDTH  beats forwarded after the trigger beat; the last of them carries tlast
- start  in  1  one-cycle pulse that begins an acquisition; honoured only in IDLE
- abort  in  1  one-cycle pulse that ends the current acquisition early
- idle  out  1  high in IDLE
- trigger_detected  out  TRIG_WIDTH  masked hit vector captured on the trigger beat
- trigger_position  out  COUNT_WIDTH  1-based index of the trigger beat within the packet
- overflow  out  1  sticky; an active-state beat was dropped because m_tready was low
- s_tdata  in  DATA_WIDTH;  s_tvalid  in  1;  s_tready  out  1  (constant 1)
- m_tdata  out  DATA_WIDTH;  m_tvalid  out  1;  m_tready  in  1;  m_tlast  out  1;  m_tuser  out  1  (high on the trigger beat)
- dbg_state  out  3  current state encoding

## Operation
- States: IDLE=0, PREBUFFER=1, ARMED=2, POST=3, FLUSH=4. Active = any state other than IDLE.
- A beat is s_tvalid in an active state. A beat is transferred when m_tready is also high. Otherwise it is dropped and overflow is set.
- Counters advance on every beat, transferred or dropped, so timing stays locked to the source.
- Passthrough rules:
  - m_tdata = s_tdata and m_tvalid = s_tvalid in active states.
  - m_tdata and m_tvalid are 0 in IDLE.
  - In IDLE, s data is discarded.
- Shadowing: start in IDLE latches prebuffer_beats, posttrigger_beats, trigger_enable and trigger_edge into shadow registers. The same start clears overflow, the beat counters and trigger_position. Config changes during an acquisition have no effect.
- Trigger hit is the reduction OR of enable & (edge ? trigger & ~trigger_q : trigger). trigger_q is trigger registered every cycle, and it is reset to 0.
- IDLE -> PREBUFFER on start. If the shadow prebuffer is 0, IDLE -> ARMED instead.
- PREBUFFER -> ARMED on the beat that brings the pre-count to the shadow prebuffer value.
- ARMED: a hit is evaluated only on cycles with a beat. A hit with no beat is ignored; edge history still updates.
- On a trigger beat:
  - m_tuser=1.
  - trigger_detected is loaded with the masked hit vector.
  - trigger_position is loaded with the total beat count including this beat.
  - Next state is POST. If the shadow post value is 0, the trigger beat also carries m_tlast and the next state is IDLE.
- POST: the post counter counts beats after the trigger. m_tlast is high on the beat where post-count+1 equals the shadow post value, and that beat moves the state to IDLE.
- Abort in PREBUFFER, ARMED or POST moves the state to FLUSH. In FLUSH, the next beat carries m_tlast, and the state then goes to IDLE. No trigger is evaluated in FLUSH.
- Abort in IDLE or FLUSH is ignored.
- Abort coincident with the normal final tlast beat: normal completion wins and the state goes to IDLE.
- Abort coincident with a trigger beat: that beat is still marked and captured, and the state goes to FLUSH.
- The total beat counter saturates at all-ones. The pre and post counters never exceed their targets.

## Timing
- Zero-latency combinational data path from s_* to m_*. m_tlast and m_tuser are combinational from state, counters, shadow registers and trigger.
- start is accepted in the cycle it is high. The first eligible beat is in the following cycle.
- idle falls the cycle after start. It rises the cycle after the tlast beat.
- Reset values: state=IDLE, idle=1, dbg_state=0, trigger_detected=0, trigger_position=0, overflow=0, all counters and shadow registers 0, trigger_q=0.
  - m_tvalid, m_tlast and m_tuser are 0 throughout reset.
  - Because trigger_q resets to 0, a trigger bit that is high out of reset counts as a rising edge.
- Reset mid-acquisition returns to IDLE immediately with no tlast issued. The downstream must tolerate the truncated packet.

## Test plan
- Basic level trigger: prebuffer=4, post=3, enable=0x1, edge=0, trigger[0] high on beat 7 -> packet of 10 beats, tuser on beat 7, tlast on beat 10, trigger_position=7, trigger_detected=0x1, idle=1 afterwards.
- Early trigger ignored: trigger high during beats 1-3 with prebuffer=4 -> no hit until ARMED. A level trigger still high hits on beat 5, so trigger_position=5.
- Edge mode: edge=0x2, trigger[1] held high from before start -> no hit. trigger[1] low then high -> hit on the rising beat only.
- Boundary values:
  - prebuffer=0, post=0 -> the first triggered beat carries both tuser and tlast, packet length 1.
  - A post change mid-acquisition does not alter tlast placement.
- Abort: abort during ARMED -> the next beat has tlast and tuser=0, then IDLE. Abort on the same cycle as the normal tlast beat -> IDLE with no extra beat.
- Backpressure and reset: m_tready low for one beat in POST -> overflow=1, tlast position unchanged, overflow cleared by the next start. stream_resetn low mid-POST -> all outputs at reset values immediately.
